// File: rtl/sync_debounce.sv
// sync_debounce
//
// Glitch filter that sits directly behind a bit synchronizer in the same
// clock domain. A new input level must be seen on STABLE_CYCLES consecutive
// dest_clk edges before the debounced output follows it. If the old level
// returns before that, the attempt is counted as a rejected glitch.
//
// Parameters:
//   STABLE_CYCLES  consecutive new-level samples needed to accept (1..65535)
//   RESET_LEVEL    D_out level and stable state after reset
//   GLITCH_W       width of the saturating glitch counter
//
// Ports:
//   dest_clk    clock, same domain as the upstream synchronizer
//   rstn        asynchronous active-low reset
//   D_in        already-synchronized input bit
//   clr_glitch  synchronous clear of glitch_cnt (wins over an increment)
//   D_out       registered debounced level
//   rise_pulse  one-cycle pulse after D_out goes 0->1
//   fall_pulse  one-cycle pulse after D_out goes 1->0
//   glitch_cnt  saturating count of aborted qualifications

module sync_debounce #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          RESET_LEVEL   = 1'b0,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                dest_clk,
    input  logic                rstn,
    input  logic                D_in,
    input  logic                clr_glitch,
    output logic                D_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    // Counter value on the edge before acceptance: when the counter already
    // holds STABLE_CYCLES-1 samples, the current sample is the last one needed.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        QUAL_HI,
        STABLE_HI,
        QUAL_LO
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             abort;

    // A qualification is aborted when the old level reappears before the
    // new level has been accepted.
    assign abort = ((state == QUAL_HI) && !D_in) || ((state == QUAL_LO) && D_in);

    always_ff @(posedge dest_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            D_out      <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            if (clr_glitch) begin
                glitch_cnt <= '0;
            end else if (abort && (glitch_cnt != {GLITCH_W{1'b1}})) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end

            unique case (state)
                STABLE_LO: begin
                    cnt <= '0;
                    if (D_in) begin
                        // With a one-sample window the first new-level
                        // sample is already the accepting one.
                        if (STABLE_CYCLES == 1) begin
                            state      <= STABLE_HI;
                            D_out      <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            state <= QUAL_HI;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end

                QUAL_HI: begin
                    if (D_in) begin
                        if (cnt == LAST_CNT) begin
                            state      <= STABLE_HI;
                            D_out      <= 1'b1;
                            rise_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end
                end

                STABLE_HI: begin
                    cnt <= '0;
                    if (!D_in) begin
                        if (STABLE_CYCLES == 1) begin
                            state      <= STABLE_LO;
                            D_out      <= 1'b0;
                            fall_pulse <= 1'b1;
                        end else begin
                            state <= QUAL_LO;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end

                QUAL_LO: begin
                    if (!D_in) begin
                        if (cnt == LAST_CNT) begin
                            state      <= STABLE_LO;
                            D_out      <= 1'b0;
                            fall_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= RESET_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The qualification counter never reaches the acceptance threshold;
    // acceptance happens on the edge that would have taken it there.
    cnt_in_range: assert property (@(posedge dest_clk) disable iff (!rstn)
        32'(cnt) < STABLE_CYCLES);

    pulses_exclusive: assert property (@(posedge dest_clk) disable iff (!rstn)
        !(rise_pulse && fall_pulse));

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
//
// Two instances: dut_a (STABLE_CYCLES=4, RESET_LEVEL=0) and
// dut_b (STABLE_CYCLES=1, RESET_LEVEL=1), sharing one clock.
// Inputs are driven on the falling edge; each driven step pushes its
// expected outputs to a scoreboard, popped and compared 1 time unit
// after the next rising edge.

module tb_sync_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, d_a, clr_a, out_a, rise_a, fall_a;
    logic [7:0] g_a;
    logic       rst_b, d_b, clr_b, out_b, rise_b, fall_b;
    logic [7:0] g_b;

    sync_debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut_a (
        .dest_clk   (clk),
        .rstn       (rst_a),
        .D_in       (d_a),
        .clr_glitch (clr_a),
        .D_out      (out_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .glitch_cnt (g_a)
    );

    sync_debounce #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b1), .GLITCH_W(8)) dut_b (
        .dest_clk   (clk),
        .rstn       (rst_b),
        .D_in       (d_b),
        .clr_glitch (clr_b),
        .D_out      (out_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .glitch_cnt (g_b)
    );

    typedef struct {
        logic       d;
        logic       clr;
        logic       o;
        logic       r;
        logic       f;
        logic [7:0] g;
    } vec_t;

    typedef struct {
        bit         sel;
        logic       o;
        logic       r;
        logic       f;
        logic [7:0] g;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_idx = 0;
    bit   sel      = 1'b0;

    // Single comparison with a FAIL line on mismatch.
    task automatic compare(input string name, input int idx,
                           input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
    endtask

    // Records the expected outputs of the selected DUT for the next check.
    task automatic pushExp(input logic o, input logic r, input logic f, input logic [7:0] g);
        exp_t e;
        e.sel = sel;
        e.o   = o;
        e.r   = r;
        e.f   = f;
        e.g   = g;
        e.idx = step_idx;
        sb.push_back(e);
        step_idx++;
    endtask

    // Pops one expectation and compares it against the matching DUT.
    task automatic checkOutput();
        exp_t       e;
        logic       o, r, f;
        logic [7:0] g;
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_empty step %0d: got 0 entries, expected 1", step_idx);
            return;
        end
        e = sb.pop_front();
        if (e.sel) begin
            o = out_b; r = rise_b; f = fall_b; g = g_b;
        end else begin
            o = out_a; r = rise_a; f = fall_a; g = g_a;
        end
        compare(e.sel ? "b_d_out" : "a_d_out", e.idx, {7'b0, o}, {7'b0, e.o});
        compare(e.sel ? "b_rise"  : "a_rise",  e.idx, {7'b0, r}, {7'b0, e.r});
        compare(e.sel ? "b_fall"  : "a_fall",  e.idx, {7'b0, f}, {7'b0, e.f});
        compare(e.sel ? "b_glitch" : "a_glitch", e.idx, g, e.g);
    endtask

    // Drives one sample on the falling edge and checks after the rising edge.
    task automatic applyStimulus(input logic d, input logic clr, input logic o,
                                 input logic r, input logic f, input logic [7:0] g);
        @(negedge clk);
        if (sel) begin
            d_b = d; clr_b = clr;
        end else begin
            d_a = d; clr_a = clr;
        end
        pushExp(o, r, f, g);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic addVec(input logic d, input logic clr, input logic o,
                          input logic r, input logic f, input logic [7:0] g);
        vec_t v;
        v.d = d; v.clr = clr; v.o = o; v.r = r; v.f = f; v.g = g;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b0; d_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b0; d_b = 1'b1; clr_b = 1'b0;
        sel   = 1'b0;

        // dut_a held in reset
        repeat (3) @(posedge clk);
        #1;
        pushExp(1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput();
        #2 rst_a = 1'b1;

        // Idle low for 10 cycles
        for (int i = 0; i < 10; i++) addVec(0, 0, 0, 0, 0, 0);
        // Clean rise, accepted on the 4th high sample
        for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 1, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 0);
        // Clean fall
        for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0);
        // Glitch: 3 highs then low
        for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1);
        // Raise to high again
        for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 1);
        addVec(1, 0, 1, 1, 0, 1);
        // Falling qualification interrupted: 0,0,1,0,0,0,0
        addVec(0, 0, 1, 0, 0, 1);
        addVec(0, 0, 1, 0, 0, 1);
        addVec(1, 0, 1, 0, 0, 2);
        for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 2);
        addVec(0, 0, 0, 0, 1, 2);
        addVec(0, 0, 0, 0, 0, 2);
        // Clear coincident with an abort
        for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 2);
        addVec(0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);

        foreach (vecs[i])
            applyStimulus(vecs[i].d, vecs[i].clr, vecs[i].o, vecs[i].r, vecs[i].f, vecs[i].g);

        // 300 one-sample glitches: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 0, 0, 0, 0, sat(i));
            applyStimulus(0, 0, 0, 0, 0, sat(i + 1));
        end
        applyStimulus(0, 1, 0, 0, 0, 0);

        // Reset while rise_pulse is high: outputs drop asynchronously
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        #1 rst_a = 1'b0;
        #1;
        pushExp(0, 0, 0, 0);
        checkOutput();
        @(posedge clk);
        #1;
        pushExp(0, 0, 0, 0);
        checkOutput();
        #1 rst_a = 1'b1;

        // Reset after 2 of 4 high samples; qualification restarts from zero
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        #1 rst_a = 1'b0;
        #1;
        pushExp(0, 0, 0, 0);
        checkOutput();
        @(posedge clk);
        #1;
        pushExp(0, 0, 0, 0);
        checkOutput();
        #1 rst_a = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);

        // dut_b: STABLE_CYCLES=1, RESET_LEVEL=1
        sel = 1'b1;
        #1;
        pushExp(1, 0, 0, 0);
        checkOutput();
        #1 rst_b = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(0, 0, 0, 0, 1, 0);
            else            applyStimulus(1, 0, 1, 1, 0, 0);
        end
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
